// File: rtl/drop_scene_ctrl.sv
// Stacking-game scene controller: swings a live block, commits drops against
// the block below, and sequences title/play/lose/win scenes. All visible state
// updates only on a frame pulse derived from the VGA vertical sync.
module drop_scene_ctrl #(
  parameter int SWING_MAX = 24,
  parameter int FRAME_DIV = 2,
  parameter int TOL       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        drop,
  input  logic        vs,
  output logic [11:0] blocks,
  output logic [59:0] pos_blocks,
  output logic [1:0]  people,
  output logic [1:0]  scene,
  output logic [3:0]  count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    LOSE = 2'd2,
    WIN  = 2'd3
  } state_t;

  localparam logic [4:0] POS_MAX  = 5'(SWING_MAX);
  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);
  localparam logic [5:0] TOL_W    = 6'(TOL);

  // Unsigned distance between two positions, widened so the subtraction
  // never wraps.
  function automatic logic [5:0] abs_diff6(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] wa;
    logic [5:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

  // vsync synchroniser (p0, p1) plus edge-history flop (p2)
  logic vs_p0, vs_p1, vs_p2;
  logic frame_pulse;

  // Game state
  state_t      state, state_nx;
  logic [11:0] blocks_nx;
  logic [4:0]  pos    [12];
  logic [4:0]  pos_nx [12];
  logic [1:0]  people_nx;
  logic [3:0]  count_nx;
  logic [3:0]  n, n_nx;
  logic        dir_up, dir_nx;
  logic [3:0]  div, div_nx;
  logic [2:0]  fcnt, fcnt_nx;
  logic        start_pend, start_pend_nx;
  logic        drop_pend, drop_pend_nx;

  logic        start_req, drop_req;
  logic [3:0]  prev_idx;
  logic [4:0]  cur_pos, prev_pos, pos_up, pos_dn;
  logic        drop_ok;

  // Synchronise vs and register a one-cycle pulse on its falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_p0       <= 1'b1;
      vs_p1       <= 1'b1;
      vs_p2       <= 1'b1;
      frame_pulse <= 1'b0;
    end else begin
      vs_p0       <= vs;
      vs_p1       <= vs_p0;
      vs_p2       <= vs_p1;
      frame_pulse <= vs_p2 & ~vs_p1;
    end
  end

  // A request arriving in the frame-pulse cycle itself still counts
  assign start_req = start_pend | start;
  assign drop_req  = drop_pend | drop;

  assign prev_idx = (n == 4'd0) ? 4'd0 : n - 4'd1;
  assign cur_pos  = pos[n];
  assign prev_pos = pos[prev_idx];
  assign pos_up   = cur_pos + 5'd1;
  assign pos_dn   = cur_pos - 5'd1;
  assign drop_ok  = (n == 4'd0) || (abs_diff6(cur_pos, prev_pos) <= TOL_W);

  // Next-state and datapath updates; everything holds except on frame_pulse
  always_comb begin
    state_nx  = state;
    blocks_nx = blocks;
    pos_nx    = pos;
    people_nx = people;
    count_nx  = count;
    n_nx      = n;
    dir_nx    = dir_up;
    div_nx    = div;
    fcnt_nx   = fcnt;
    start_pend_nx = frame_pulse ? 1'b0 : start_req;
    drop_pend_nx  = frame_pulse ? 1'b0 : drop_req;

    if (frame_pulse) begin
      unique case (state)
        PLAY: begin
          fcnt_nx = fcnt + 3'd1;
          if (fcnt == 3'd7) people_nx = people + 2'd1;
          if (drop_req) begin
            if (drop_ok) begin
              count_nx = count + 4'd1;
              if (count_nx == 4'd12) begin
                state_nx  = WIN;
                people_nx = 2'd3;
              end else begin
                n_nx              = count_nx;
                blocks_nx[count_nx] = 1'b1;
                pos_nx[count_nx]  = 5'd0;
                dir_nx            = 1'b1;
                div_nx            = 4'd0;
              end
            end else begin
              blocks_nx[n] = 1'b0;
              state_nx     = LOSE;
            end
          end else if (div == DIV_LAST) begin
            div_nx = 4'd0;
            if (dir_up) begin
              pos_nx[n] = pos_up;
              if (pos_up == POS_MAX) dir_nx = 1'b0;
            end else begin
              pos_nx[n] = pos_dn;
              if (pos_dn == 5'd0) dir_nx = 1'b1;
            end
          end else begin
            div_nx = div + 4'd1;
          end
        end
        default: begin
          // IDLE, LOSE, WIN: only start matters; a pending drop is discarded
          if (start_req) begin
            state_nx  = PLAY;
            blocks_nx = 12'h001;
            for (int k = 0; k < 12; k++) pos_nx[k] = 5'd0;
            count_nx  = 4'd0;
            n_nx      = 4'd0;
            dir_nx    = 1'b1;
            div_nx    = 4'd0;
            fcnt_nx   = 3'd0;
            people_nx = 2'd0;
          end
        end
      endcase
    end
  end

  // Game state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      blocks     <= 12'h000;
      for (int k = 0; k < 12; k++) pos[k] <= 5'd0;
      people     <= 2'd0;
      count      <= 4'd0;
      n          <= 4'd0;
      dir_up     <= 1'b1;
      div        <= 4'd0;
      fcnt       <= 3'd0;
      start_pend <= 1'b0;
      drop_pend  <= 1'b0;
    end else begin
      state      <= state_nx;
      blocks     <= blocks_nx;
      pos        <= pos_nx;
      people     <= people_nx;
      count      <= count_nx;
      n          <= n_nx;
      dir_up     <= dir_nx;
      div        <= div_nx;
      fcnt       <= fcnt_nx;
      start_pend <= start_pend_nx;
      drop_pend  <= drop_pend_nx;
    end
  end

  // Pack slot positions onto the flat output bus
  always_comb begin
    pos_blocks = '0;
    for (int k = 0; k < 12; k++) pos_blocks[5*k +: 5] = pos[k];
  end

  assign scene = state;

endmodule

// File: tb/tb_drop_scene_ctrl.sv
// Scoreboard bench for drop_scene_ctrl: the stimulus thread queues the
// expected outputs for each vsync frame, a monitor thread compares them once
// the frame has settled and flags any output change outside a frame update.
module tb_drop_scene_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, drop, vs;
  logic [11:0] blocks;
  logic [59:0] pos_blocks;
  logic [1:0]  people, scene;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;

  localparam logic [59:0] ALL = {60{1'b1}};

  drop_scene_ctrl #(.SWING_MAX(24), .FRAME_DIV(2), .TOL(4)) dut (
    .clk(clk), .reset(reset), .start(start), .drop(drop), .vs(vs),
    .blocks(blocks), .pos_blocks(pos_blocks), .people(people),
    .scene(scene), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [1:0]  scene;
    logic [11:0] blocks;
    logic [3:0]  count;
    logic [59:0] pos;
    logic [59:0] pmask;
    bit          chk_people;
    logic [1:0]  people;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [59:0] slot(input int k, input logic [4:0] v);
    logic [59:0] r;
    r = '0;
    r[5*k +: 5] = v;
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic vs_pulse();
    @(posedge clk); #2 vs = 1'b0;
    repeat (4) @(posedge clk);
    #2 vs = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic pulse_drop();
    @(posedge clk); #2 drop = 1'b1;
    @(posedge clk); #2 drop = 1'b0;
  endtask

  task automatic push_exp(input bit c, input logic [1:0] sc, input logic [11:0] bl,
                          input logic [3:0] cn, input logic [59:0] p, input logic [59:0] m,
                          input bit cp, input logic [1:0] pp);
    exp_t e;
    e.chk = c; e.scene = sc; e.blocks = bl; e.count = cn;
    e.pos = p; e.pmask = m; e.chk_people = cp; e.people = pp;
    exp_q.push_back(e);
  endtask

  task automatic frame_chk(input logic [1:0] sc, input logic [11:0] bl, input logic [3:0] cn,
                           input logic [59:0] p, input logic [59:0] m,
                           input bit cp, input logic [1:0] pp);
    push_exp(1'b1, sc, bl, cn, p, m, cp, pp);
    vs_pulse();
  endtask

  task automatic frame_skip(input int k);
    for (int i = 0; i < k; i++) begin
      push_exp(1'b0, 2'd0, 12'h0, 4'd0, 60'd0, 60'd0, 1'b0, 2'd0);
      vs_pulse();
    end
  endtask

  // ---------------- monitor ----------------
  logic [79:0] prev_snap, cur_snap;
  bit          have_prev = 1'b0;
  logic        vs_q = 1'b1;
  logic        rst_q = 1'b1;
  int          since = 100;
  int          fidx = 0;
  exp_t        me;

  always @(negedge clk) begin
    cur_snap = {scene, count, people, blocks, pos_blocks};
    if (vs_q && !vs) since = 0;
    else if (since < 100) since++;
    vs_q = vs;
    if (have_prev && cur_snap !== prev_snap) begin
      checks++;
      if (!(reset || rst_q || (since >= 2 && since <= 5))) begin
        failures++;
        $display("FAIL mid_frame_change since=%0d actual=%0h required=%0h", since, cur_snap, prev_snap);
      end
    end
    prev_snap = cur_snap;
    rst_q     = reset;
    have_prev = 1'b1;
    if (since == 7) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=frame_seen required=no_frame");
      end else begin
        me = exp_q.pop_front();
        fidx++;
        if (me.chk) begin
          check($sformatf("scene@f%0d", fidx),  64'(scene),  64'(me.scene));
          check($sformatf("blocks@f%0d", fidx), 64'(blocks), 64'(me.blocks));
          check($sformatf("count@f%0d", fidx),  64'(count),  64'(me.count));
          check($sformatf("pos@f%0d", fidx), 64'(pos_blocks & me.pmask), 64'(me.pos & me.pmask));
          if (me.chk_people)
            check($sformatf("people@f%0d", fidx), 64'(people), 64'(me.people));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; drop = 1'b0; vs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scene",  64'(scene),      64'd0);
    check("rst_blocks", 64'(blocks),     64'd0);
    check("rst_pos",    64'(pos_blocks), 64'd0);
    check("rst_count",  64'(count),      64'd0);
    check("rst_people", 64'(people),     64'd0);
    @(posedge clk); #2 reset = 1'b0;

    // Drop on the title screen is discarded
    pulse_drop();
    frame_chk(2'd0, 12'h000, 4'd0, 60'd0, ALL, 1'b1, 2'd0);

    // Start takes effect only at the next frame
    pulse_start();
    @(posedge clk); #1;
    check("pre_frame_scene",  64'(scene),  64'd0);
    check("pre_frame_blocks", 64'(blocks), 64'd0);
    frame_chk(2'd1, 12'h001, 4'd0, 60'd0, ALL, 1'b1, 2'd0);

    // Swing of slot 0 with FRAME_DIV=2
    frame_chk(2'd1, 12'h001, 4'd0, slot(0, 5'd0),  slot(0, 5'h1f), 1'b0, 2'd0); // f1
    frame_chk(2'd1, 12'h001, 4'd0, slot(0, 5'd1),  slot(0, 5'h1f), 1'b0, 2'd0); // f2
    frame_skip(4);                                                               // f3..f6
    frame_chk(2'd1, 12'h001, 4'd0, slot(0, 5'd3),  slot(0, 5'h1f), 1'b1, 2'd0); // f7
    frame_chk(2'd1, 12'h001, 4'd0, slot(0, 5'd4),  slot(0, 5'h1f), 1'b1, 2'd1); // f8
    frame_skip(39);                                                              // f9..f47
    frame_chk(2'd1, 12'h001, 4'd0, slot(0, 5'd24), slot(0, 5'h1f), 1'b0, 2'd0); // f48
    frame_chk(2'd1, 12'h001, 4'd0, slot(0, 5'd24), slot(0, 5'h1f), 1'b0, 2'd0); // f49
    frame_chk(2'd1, 12'h001, 4'd0, slot(0, 5'd23), slot(0, 5'h1f), 1'b0, 2'd0); // f50
    frame_skip(9);                                                               // f51..f59
    frame_chk(2'd1, 12'h001, 4'd0, slot(0, 5'd18), slot(0, 5'h1f), 1'b1, 2'd3); // f60

    // Start during play is ignored and does not linger
    pulse_start();
    frame_chk(2'd1, 12'h001, 4'd0, slot(0, 5'd18), slot(0, 5'h1f), 1'b0, 2'd0); // f61
    frame_chk(2'd1, 12'h001, 4'd0, slot(0, 5'd17), slot(0, 5'h1f), 1'b0, 2'd0); // f62
    frame_skip(13);                                                              // f63..f75
    frame_chk(2'd1, 12'h001, 4'd0, slot(0, 5'd10), slot(0, 5'h1f), 1'b0, 2'd0); // f76

    // Slot 0 dropped at 10, slot 1 swings to 13 and lands within tolerance
    pulse_drop();
    frame_chk(2'd1, 12'h003, 4'd1, slot(0, 5'd10), slot(0, 5'h1f) | slot(1, 5'h1f), 1'b0, 2'd0);
    frame_skip(25);
    frame_chk(2'd1, 12'h003, 4'd1, slot(0, 5'd10) | slot(1, 5'd13),
              slot(0, 5'h1f) | slot(1, 5'h1f), 1'b0, 2'd0);
    pulse_drop();
    frame_chk(2'd1, 12'h007, 4'd2, slot(0, 5'd10) | slot(1, 5'd13),
              slot(0, 5'h1f) | slot(1, 5'h1f) | slot(2, 5'h1f), 1'b0, 2'd0);

    // Start and drop both pending in play: drop wins, slot 2 at 0 misses 13
    pulse_start();
    pulse_drop();
    frame_chk(2'd2, 12'h003, 4'd2, slot(0, 5'd10) | slot(1, 5'd13),
              slot(0, 5'h1f) | slot(1, 5'h1f) | slot(2, 5'h1f), 1'b0, 2'd0);
    // Drop while lost is ignored
    pulse_drop();
    frame_chk(2'd2, 12'h003, 4'd2, slot(0, 5'd10) | slot(1, 5'd13),
              slot(0, 5'h1f) | slot(1, 5'h1f), 1'b0, 2'd0);

    // Restart; slot 0 at 10, slot 1 at 15 is out of tolerance
    pulse_start();
    frame_chk(2'd1, 12'h001, 4'd0, 60'd0, ALL, 1'b0, 2'd0);
    frame_skip(19);
    frame_chk(2'd1, 12'h001, 4'd0, slot(0, 5'd10), slot(0, 5'h1f), 1'b0, 2'd0);
    pulse_drop();
    frame_chk(2'd1, 12'h003, 4'd1, slot(0, 5'd10), slot(0, 5'h1f) | slot(1, 5'h1f), 1'b0, 2'd0);
    frame_skip(29);
    frame_chk(2'd1, 12'h003, 4'd1, slot(0, 5'd10) | slot(1, 5'd15),
              slot(0, 5'h1f) | slot(1, 5'h1f), 1'b0, 2'd0);
    pulse_drop();
    frame_chk(2'd2, 12'h001, 4'd1, slot(0, 5'd10) | slot(1, 5'd15),
              slot(0, 5'h1f) | slot(1, 5'h1f), 1'b0, 2'd0);

    // Start and drop both pending outside play: start wins
    pulse_start();
    pulse_drop();
    frame_chk(2'd1, 12'h001, 4'd0, 60'd0, ALL, 1'b0, 2'd0);
    // Eleven stacked drops at position 0
    for (int i = 1; i <= 11; i++) begin
      pulse_drop();
      frame_chk(2'd1, 12'((13'd1 << (i + 1)) - 13'd1), 4'(i), 60'd0, ALL, 1'b0, 2'd0);
    end
    // Twelfth drop wins
    pulse_drop();
    frame_chk(2'd3, 12'hFFF, 4'd12, 60'd0, ALL, 1'b1, 2'd3);
    pulse_drop();
    frame_chk(2'd3, 12'hFFF, 4'd12, 60'd0, ALL, 1'b1, 2'd3);
    pulse_start();
    frame_chk(2'd1, 12'h001, 4'd0, 60'd0, ALL, 1'b0, 2'd0);

    // Mid-game reset with a drop pending and a frame in flight
    frame_skip(5);
    push_exp(1'b1, 2'd0, 12'h000, 4'd0, 60'd0, ALL, 1'b1, 2'd0);
    pulse_drop();
    @(posedge clk); #2 vs = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("midrst_scene",  64'(scene),      64'd0);
    check("midrst_blocks", 64'(blocks),     64'd0);
    check("midrst_pos",    64'(pos_blocks), 64'd0);
    check("midrst_count",  64'(count),      64'd0);
    check("midrst_people", 64'(people),     64'd0);
    repeat (3) @(posedge clk);
    #2 vs = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (4) @(posedge clk);
    // A real frame after reset without start stays on the title
    frame_chk(2'd0, 12'h000, 4'd0, 60'd0, ALL, 1'b1, 2'd0);

    repeat (15) @(posedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drop_scene_ctrl.md
DROP_SCENE_CTRL -- requirements
Module: drop_scene_ctrl

Interface
REQ-001 Parameter SWING_MAX, default 24: highest live-block position; the position bounces over the range 0..SWING_MAX.
REQ-002 Parameter FRAME_DIV, default 2: number of frames per swing step; legal range 1..15.
REQ-003 Parameter TOL, default 4: maximum allowed |pos difference| between the dropped block and the block below it.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; starts a game from IDLE, WIN or LOSE.
REQ-007 drop  in  1  one-cycle pulse; requests a drop of the live block.
REQ-008 vs  in  1  VGA vertical sync, active low, asynchronous to clk.
REQ-009 blocks  out  12  slot-occupied flags; bit k is slot k.
REQ-010 pos_blocks  out  60  slot positions; slot k occupies bits [5k+4:5k], unsigned.
REQ-011 people  out  2  character animation frame.
REQ-012 scene  out  2  scene select: 0 = title, 1 = play, 2 = lose, 3 = win.
REQ-013 count  out  4  number of blocks placed, 0..12.

Function
REQ-014 vs shall be synchronised through two flops; the falling edge of the synchronised signal shall produce frame_pulse, one clk cycle wide, delayed 3 cycles from the vs edge.
REQ-015 All changes to blocks, pos_blocks, people, scene and count shall occur only on a frame_pulse cycle, so nothing changes mid-frame.
REQ-016 The FSM shall have states IDLE, PLAY, LOSE and WIN, with scene equal to 0, 1, 2 and 3 respectively.
REQ-017 start and drop shall each set a sticky pending flag; the flag is cleared when it is consumed at a frame_pulse or when it is ignored at a frame_pulse.
REQ-018 Transition IDLE/LOSE/WIN -> PLAY on frame_pulse with start pending, with these effects:
  - blocks = 12'h001;
  - pos_blocks = 0;
  - count = 0;
  - live slot n = 0;
  - direction = up;
  - divider = 0.
REQ-019 In PLAY, the divider shall count frame_pulses 0..FRAME_DIV-1. On wrap, the live position shall step by 1 in the current direction:
  - reaching SWING_MAX reverses the direction to down;
  - reaching 0 reverses the direction to up;
  - each endpoint is held for exactly one step.
REQ-020 In PLAY, a frame_pulse with drop pending shall commit the drop instead of performing a swing step. The drop succeeds if n = 0, or if |pos[n] - pos[n-1]| <= TOL, computed 6 bits wide and unsigned-safe.
REQ-021 On a successful drop:
  - count increments;
  - if the new count is 12, go to WIN;
  - otherwise n = count, blocks[n] = 1, pos[n] = 0, direction = up, divider = 0.
REQ-022 On a failed drop, clear blocks[n], leave pos[n] unchanged, leave count unchanged, and go to LOSE.
REQ-023 start pending while in PLAY shall be ignored and cleared at the next frame_pulse.
REQ-024 drop pending outside PLAY shall be ignored and cleared at the next frame_pulse.
REQ-025 If start and drop are both pending, start governs outside PLAY and drop governs in PLAY.
REQ-026 people shall increment (wrapping 3 -> 0) every 8th frame_pulse in PLAY, using a 3-bit frame counter. people shall be held at 0 in IDLE and at 3 in WIN. In LOSE it shall freeze at its current value.
REQ-027 Placed slots (index < n) shall never change until the next start.

Reset
REQ-028 Asserting reset shall immediately force the following:
  - state = IDLE, scene = 0;
  - blocks = 0, pos_blocks = 0;
  - people = 0, count = 0;
  - pending flags = 0, divider = 0;
  - synchroniser flops = 1.
REQ-029 Reset asserted mid-game shall abandon the game with no partial commit. After release, the first frame_pulse requires a real vs falling edge.

Verification
REQ-030 Reset, then start, then one vs low pulse -> scene = 1, blocks = 12'h001, pos_blocks = 0, count = 0. No output changes before the frame_pulse.
REQ-031 PLAY with FRAME_DIV = 2, 60 vs pulses, no drop -> pos[0] follows 1 at frame 2, 24 at frame 48, and 23 at frame 50. Outputs never change on non-frame_pulse cycles.
REQ-032 Drop with n = 0 at pos 10, then drop slot 1 at pos 13 -> count = 2, blocks = 12'h007, pos[1] = 13, pos[2] = 0.
REQ-033 Slot 0 at 10, drop slot 1 at 15 -> scene = 2, blocks = 12'h001, count = 1.
REQ-034 Twelve successful drops -> scene = 3, count = 12, blocks = 12'hFFF, people = 3. A further drop is ignored. A start then restarts with blocks = 12'h001.
REQ-035 Pulse drop and reset in the same window mid-game -> all outputs 0 and scene = 0 immediately. A post-release vs pulse with no start leaves scene = 0.
